// File: rtl/cell_plot_arbiter.sv
// cell_plot_arbiter: round-robin arbiter expanding grid-cell paint requests into pixel plot bursts.
// Optional CELL_ARB_BORDER_EN paints the right/bottom pixel row of each cell in blue.
module cell_plot_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int GRID_SIZE  = 28,
  parameter int PIXEL_SIZE = 4,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [5*NUM_REQ-1:0]   req_x,
  input  logic [5*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic                   done,
  output logic                   busy,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, PAINT = 2'd1, DROP = 2'd2;
  localparam logic [2:0] PM = 3'(PIXEL_SIZE - 1);
`ifdef CELL_ARB_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  logic [1:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [7:0]    r_bx;
  logic [6:0]    r_by;
  logic [2:0]    r_col, r_ox, r_oy;
  logic          w_any, w_ok, w_last;
  logic [IW-1:0] w_idx, w_j;
  logic [4:0]    w_cx, w_cy;
  logic [2:0]    w_col, w_nox, w_noy;
  logic [7:0]    w_bx;
  logic [6:0]    w_by;
  // Descending scan: the last hit written is the one closest after r_ptr.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = IW'((int'(r_ptr) + k) % NUM_REQ);
      if (req[w_j]) begin
        w_any = 1'b1;
        w_idx = w_j;
      end
    end
  end
  assign w_cx   = 5'(req_x >> (5 * w_idx));
  assign w_cy   = 5'(req_y >> (5 * w_idx));
  assign w_col  = 3'(req_colour >> (3 * w_idx));
  assign w_bx   = 8'(X_ORIGIN + int'(w_cx) * PIXEL_SIZE);
  assign w_by   = 7'(Y_ORIGIN + int'(w_cy) * PIXEL_SIZE);
  assign w_ok   = (int'(w_cx) < GRID_SIZE) && (int'(w_cy) < GRID_SIZE);
  assign w_last = (r_ox == PM) && (r_oy == PM);
  assign w_nox  = (r_ox == PM) ? 3'd0 : r_ox + 3'd1;
  assign w_noy  = (r_ox == PM) ? r_oy + 3'd1 : r_oy;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_bx    <= '0;
      r_by    <= '0;
      r_col   <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      ack     <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
    end else begin
      ack  <= '0;
      err  <= 1'b0;
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_any) begin
          r_ptr   <= w_idx;
          ack     <= NUM_REQ'(1) << w_idx;
          r_bx    <= w_bx;
          r_by    <= w_by;
          r_col   <= w_col;
          r_ox    <= '0;
          r_oy    <= '0;
          busy    <= 1'b1;
          r_state <= w_ok ? PAINT : DROP;
          plot    <= w_ok;
          x       <= w_ok ? w_bx : x;
          y       <= w_ok ? w_by : y;
          colour  <= w_ok ? ((BORDER && PM == 3'd0) ? 3'b001 : w_col) : colour;
        end
      end else if (r_state == DROP) begin
        r_state <= IDLE;
        err     <= 1'b1;
        busy    <= 1'b0;
      end else if (w_last) begin
        r_state <= IDLE;
        done    <= 1'b1;
        busy    <= 1'b0;
        plot    <= 1'b0;
      end else begin
        r_ox   <= w_nox;
        r_oy   <= w_noy;
        x      <= r_bx + {5'd0, w_nox};
        y      <= r_by + {4'd0, w_noy};
        colour <= (BORDER && (w_nox == PM || w_noy == PM)) ? 3'b001 : r_col;
      end
    end
  end
endmodule
